// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: valid/ready flow-control sequencer for the pipelined mat_mul
// tree-sum datapath. This block tracks the jobs in flight, carries a tag with
// each job, supports flush, and keeps saturating performance counters.
// Operands go directly from the source to mat_mul. This block drives only
// mat_mul's cen and the handshake/status signals.
module mat_mul_ctrl #(
  parameter int N     = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             mm_cen,
  input  logic             flush,
  output logic             idle,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Number of register stages inside mat_mul. It is fixed by N.
  localparam int DEPTH = $clog2(N);

  // Index 0 is the first datapath stage. Index DEPTH-1 is the result stage.
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];

  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic advance_s;
  logic mid_busy_s;
  logic accept_s;
  logic retire_s;
  logic stall_s;

  // Increment a counter unless it is already all-ones. The counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Handshake and clock-enable decode. The datapath is clocked only when
  // something other than a bubble would move through it.
  always_comb begin
    mid_busy_s = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      mid_busy_s = mid_busy_s | vld_q[k];
    end
    advance_s = !vld_q[DEPTH-1] || out_ready;
    in_ready  = advance_s && !flush;
    mm_cen    = advance_s && !flush && (in_valid || mid_busy_s);
    out_valid = vld_q[DEPTH-1];
    out_tag   = tag_q[DEPTH-1];
    idle      = (vld_q == {DEPTH{1'b0}});
    accept_s  = in_valid && in_ready;
    retire_s  = out_valid && out_ready && !flush;
    stall_s   = out_valid && !out_ready;
  end

  // Next state of the valid/tag shift registers. The whole pipe moves as one
  // unit, and bubbles are not collapsed. Flush clears valids and leaves the
  // tags stale.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (flush) begin
      vld_d = {DEPTH{1'b0}};
    end else if (advance_s) begin
      vld_d[0] = in_valid;
      tag_d[0] = in_tag;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end else begin
      vld_d = vld_q;
      tag_d = tag_q;
    end
  end

  // Next state of the saturating performance counters.
  always_comb begin
    issued_d  = sat_inc(issued_q, accept_s);
    retired_d = sat_inc(retired_q, retire_s);
    stall_d   = sat_inc(stall_q, stall_s);
  end

  // State registers. An asynchronous reset discards every in-flight job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= {TAG_W{1'b0}};
      end
      issued_q  <= {CNT_W{1'b0}};
      retired_q <= {CNT_W{1'b0}};
      stall_q   <= {CNT_W{1'b0}};
    end else begin
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  // Drive the counter outputs directly from their registers.
  always_comb begin
    issued_cnt  = issued_q;
    retired_cnt = retired_q;
    stall_cnt   = stall_q;
  end

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Testbench for mat_mul_ctrl.
// Instance A uses N=2 (one stage) and CNT_W=3. Instance B uses N=4 (two stages).
// Each instance drives a small stand-in datapath that is clocked by its mm_cen.
// Expected behaviour comes from a job-level scoreboard (queue of jobs with
// their stage position).
module tb_mat_mul_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // Instance A: N=2, CNT_W=3
  logic       a_iv, a_ir, a_ov, a_or, a_cen, a_fl, a_idle;
  logic [3:0] a_itag, a_otag;
  logic [2:0] a_iss, a_ret, a_stl;

  // Instance B: N=4, CNT_W=16
  logic        b_iv, b_ir, b_ov, b_or, b_cen, b_fl, b_idle;
  logic [3:0]  b_itag, b_otag;
  logic [15:0] b_iss, b_ret, b_stl;

  int n_chk  = 0;
  int n_fail = 0;

  mat_mul_ctrl #(.N(2), .TAG_W(4), .CNT_W(3)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(a_iv), .in_ready(a_ir), .in_tag(a_itag),
    .out_valid(a_ov), .out_ready(a_or), .out_tag(a_otag), .mm_cen(a_cen),
    .flush(a_fl), .idle(a_idle), .issued_cnt(a_iss), .retired_cnt(a_ret),
    .stall_cnt(a_stl));

  mat_mul_ctrl #(.N(4), .TAG_W(4), .CNT_W(16)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(b_iv), .in_ready(b_ir), .in_tag(b_itag),
    .out_valid(b_ov), .out_ready(b_or), .out_tag(b_otag), .mm_cen(b_cen),
    .flush(b_fl), .idle(b_idle), .issued_cnt(b_iss), .retired_cnt(b_ret),
    .stall_cnt(b_stl));

  // Stand-in datapath for A: one cen-gated stage computing the 2x2 product.
  int a_m1 [4];
  int a_m2 [4];
  logic [63:0] a_res;

  function automatic logic [63:0] mm2(input int m1 [4], input int m2 [4]);
    logic [63:0] r;
    int s;
    r = 64'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s = s + m1[i*2+k] * m2[k*2+j];
        r[(3-(i*2+j))*16 +: 16] = s[15:0];
      end
    end
    return r;
  endfunction

  always @(posedge clk) if (a_cen) a_res <= mm2(a_m1, a_m2);

  // Stand-in datapath for B: two cen-gated stages carrying the job payload.
  logic [31:0] b_src, b_p0, b_p1;
  always @(posedge clk) begin
    if (b_cen) begin
      b_p0 <= b_src;
      b_p1 <= b_p0;
    end
  end

  // Job-level reference for B. Each job has a position of 1..DEPTH.
  int          q_pos [$];
  logic [3:0]  q_tag [$];
  logic [31:0] q_dat [$];
  int m_iss, m_ret, m_stl;

  task automatic chk(input string name, input longint unsigned obs,
                     input longint unsigned exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic b_model_clear();
    q_pos.delete();
    q_tag.delete();
    q_dat.delete();
    m_iss = 0;
    m_ret = 0;
    m_stl = 0;
  endtask

  // Apply one cycle of stimulus to B and check every output against the
  // model. Then advance the model by the clock edge.
  task automatic b_cycle(input logic iv, input logic [3:0] tg,
                         input logic ordy, input logic fl);
    logic done, adv, rdy, mid;
    @(negedge clk);
    b_iv = iv; b_itag = tg; b_or = ordy; b_fl = fl; b_src = $urandom();
    #1;
    done = (q_pos.size() > 0) && (q_pos[0] == 2);
    adv  = !done || ordy;
    rdy  = adv && !fl;
    mid  = 1'b0;
    foreach (q_pos[i]) if (q_pos[i] < 2) mid = 1'b1;
    chk("b_in_ready", b_ir, rdy);
    chk("b_out_valid", b_ov, done);
    chk("b_mm_cen", b_cen, rdy && (iv || mid));
    chk("b_idle", b_idle, q_pos.size() == 0);
    if (done) begin
      chk("b_out_tag", b_otag, q_tag[0]);
      chk("b_result", b_p1, q_dat[0]);
    end
    chk("b_issued", b_iss, m_iss);
    chk("b_retired", b_ret, m_ret);
    chk("b_stall", b_stl, m_stl);
    if (iv && rdy) m_iss++;
    if (done && ordy && !fl) m_ret++;
    if (done && !ordy) m_stl++;
    if (fl) begin
      q_pos.delete(); q_tag.delete(); q_dat.delete();
    end else if (adv) begin
      if (done) begin
        void'(q_pos.pop_front()); void'(q_tag.pop_front()); void'(q_dat.pop_front());
      end
      foreach (q_pos[i]) q_pos[i] = q_pos[i] + 1;
      if (iv) begin
        q_pos.push_back(1); q_tag.push_back(tg); q_dat.push_back(b_src);
      end
    end
  endtask

  task automatic a_drive(input logic iv, input logic [3:0] tg, input logic ordy);
    @(negedge clk);
    a_iv = iv; a_itag = tg; a_or = ordy; a_fl = 1'b0;
    #1;
  endtask

  logic [15:0] s0, r0;

  initial begin
    rstn = 1'b0;
    a_iv = 1'b0; a_itag = 4'd0; a_or = 1'b1; a_fl = 1'b0;
    b_iv = 1'b0; b_itag = 4'd0; b_or = 1'b1; b_fl = 1'b0; b_src = 32'd0;
    a_m1 = '{1, 2, 3, 4};
    a_m2 = '{5, 6, 7, 8};
    b_model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("a_rst_out_valid", a_ov, 1'b0);
    chk("a_rst_out_tag", a_otag, 4'd0);
    chk("a_rst_in_ready", a_ir, 1'b1);
    chk("a_rst_idle", a_idle, 1'b1);
    chk("a_rst_mm_cen", a_cen, 1'b0);
    chk("b_rst_out_valid", b_ov, 1'b0);
    chk("b_rst_in_ready", b_ir, 1'b1);
    chk("b_rst_idle", b_idle, 1'b1);
    chk("b_rst_mm_cen", b_cen, 1'b0);
    chk("b_rst_issued", b_iss, 16'd0);
    @(negedge clk);
    rstn = 1'b1;

    // A: a single job with the known 2x2 product and one-cycle latency
    a_drive(1'b1, 4'd3, 1'b1);
    chk("a_accept_ready", a_ir, 1'b1);
    chk("a_accept_cen", a_cen, 1'b1);
    chk("a_accept_ovalid", a_ov, 1'b0);
    a_drive(1'b0, 4'd0, 1'b1);
    chk("a_out_valid", a_ov, 1'b1);
    chk("a_out_tag", a_otag, 4'd3);
    chk("a_result", a_res, 64'h0013_0016_002B_0032);
    chk("a_busy", a_idle, 1'b0);
    chk("a_cen_bubble", a_cen, 1'b0);
    a_drive(1'b0, 4'd0, 1'b1);
    chk("a_done_ovalid", a_ov, 1'b0);
    chk("a_done_idle", a_idle, 1'b1);
    chk("a_issued_1", a_iss, 3'd1);
    chk("a_retired_1", a_ret, 3'd1);

    // B: 8 back-to-back jobs with tags 0..7 and full throughput
    for (int i = 0; i < 8; i++) b_cycle(1'b1, 4'(i), 1'b1, 1'b0);
    repeat (3) b_cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("b_b2b_issued", b_iss, 16'd8);
    chk("b_b2b_retired", b_ret, 16'd8);
    chk("b_b2b_stall", b_stl, 16'd0);

    // B: hold the output for 5 cycles of backpressure
    s0 = b_stl; r0 = b_ret;
    b_cycle(1'b1, 4'd9, 1'b0, 1'b0);
    b_cycle(1'b1, 4'd10, 1'b0, 1'b0);
    repeat (5) b_cycle(1'b1, 4'd11, 1'b0, 1'b0);
    repeat (4) b_cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("b_stall_5", b_stl - s0, 16'd5);
    chk("b_stall_retire_2", b_ret - r0, 16'd2);

    // B: flush with two jobs in flight, then one normal job
    r0 = b_ret;
    b_cycle(1'b1, 4'd1, 1'b1, 1'b0);
    b_cycle(1'b1, 4'd2, 1'b1, 1'b0);
    b_cycle(1'b1, 4'd3, 1'b1, 1'b1);
    b_cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("b_flush_retired", b_ret, r0);
    b_cycle(1'b1, 4'd4, 1'b1, 1'b0);
    repeat (3) b_cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("b_post_flush_retired", b_ret - r0, 16'd1);

    // Asynchronous reset asserted between edges while jobs are in flight
    b_cycle(1'b1, 4'd5, 1'b1, 1'b0);
    b_cycle(1'b1, 4'd6, 1'b1, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("b_arst_out_valid", b_ov, 1'b0);
    chk("b_arst_idle", b_idle, 1'b1);
    chk("b_arst_in_ready", b_ir, 1'b1);
    chk("b_arst_issued", b_iss, 16'd0);
    chk("b_arst_retired", b_ret, 16'd0);
    chk("b_arst_stall", b_stl, 16'd0);
    chk("a_arst_issued", a_iss, 3'd0);
    b_model_clear();
    @(negedge clk);
    b_iv = 1'b0; b_fl = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // A: 9 jobs with CNT_W=3, so the counters saturate at 7
    for (int i = 0; i < 9; i++) a_drive(1'b1, 4'(i), 1'b1);
    chk("a_sat_issued_hold", a_iss, 3'd7);
    a_drive(1'b0, 4'd0, 1'b1);
    a_drive(1'b0, 4'd0, 1'b1);
    chk("a_sat_issued", a_iss, 3'd7);
    chk("a_sat_retired", a_ret, 3'd7);
    chk("a_sat_stall", a_stl, 3'd0);

    // B: randomized traffic with random backpressure and occasional flush
    repeat (400) b_cycle($urandom_range(0, 3) != 0, 4'($urandom()),
                         $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    repeat (4) b_cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("b_final_idle", b_idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
